// File: rtl/cpu_pkg.sv
// Shared core definitions: data width, reset PC and the boot sequencer state encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    BOOT_IDLE    = 3'd0,
    BOOT_LOAD    = 3'd1,
    BOOT_CHECK   = 3'd2,
    BOOT_RELEASE = 3'd3,
    BOOT_RUN     = 3'd4
  } boot_state_e;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams a program into imem, forces the PC, then releases the CPU.
// Optional trailing checksum word enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 10,
  parameter int unsigned     DATA_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_start,
  input  logic [ADDR_W:0]   boot_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              pc_load,
  output logic [XLEN-1:0]   pc_init,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'(BOOT_IDLE);
  localparam logic [2:0] S_LOAD    = 3'(BOOT_LOAD);
  localparam logic [2:0] S_CHECK   = 3'(BOOT_CHECK);
  localparam logic [2:0] S_RELEASE = 3'(BOOT_RELEASE);
  localparam logic [2:0] S_RUN     = 3'(BOOT_RUN);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [2:0]        state, state_n;
  logic [ADDR_W:0]   len, len_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic              s_ready_n, imem_we_n, cpu_hold_n, pc_load_n, busy_n, done_n, err_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [DATA_W-1:0] imem_wdata_n;
  logic              hs, len_ok;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [XLEN-1:0]   sum, sum_n;
`endif

  assign pc_init = RESET_PC;
  assign hs      = s_valid & s_ready;
  assign len_ok  = (boot_len != '0) && (boot_len <= MAX_LEN);

  // Next-state and next-output logic; every output is the registered image of its _n value.
  always_comb begin
    state_n      = state;
    len_n        = len;
    cnt_n        = cnt;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    cpu_hold_n   = cpu_hold;
    pc_load_n    = 1'b0;
    done_n       = done;
    err_n        = err;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_n        = sum;
`endif
    case (state)
      S_IDLE, S_RUN: begin
        if (boot_start) begin
          if (len_ok) begin
            state_n    = S_LOAD;
            len_n      = boot_len;
            cnt_n      = '0;
            err_n      = 1'b0;
            cpu_hold_n = 1'b1;
            done_n     = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_n      = '0;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          imem_we_n    = 1'b1;
          imem_addr_n  = cnt[ADDR_W-1:0];
          imem_wdata_n = s_data;
          cnt_n        = cnt + ONE;
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_n        = sum + XLEN'(s_data);
          if (cnt == len - ONE) state_n = S_CHECK;
`else
          if (cnt == len - ONE) begin
            state_n   = S_RELEASE;
            pc_load_n = 1'b1;
          end
`endif
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (hs) begin
          if (XLEN'(s_data) == sum) begin
            state_n   = S_RELEASE;
            pc_load_n = 1'b1;
          end else begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end
        end
      end
`endif
      S_RELEASE: begin
        state_n    = S_RUN;
        cpu_hold_n = 1'b0;
        done_n     = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    s_ready_n = (state_n == S_LOAD) || (state_n == S_CHECK);
    busy_n    = (state_n == S_LOAD) || (state_n == S_CHECK) || (state_n == S_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= '0;
      cnt        <= '0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      pc_load    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_n;
      len        <= len_n;
      cnt        <= cnt_n;
      s_ready    <= s_ready_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      cpu_hold   <= cpu_hold_n;
      pc_load    <= pc_load_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum        <= sum_n;
`endif
    end
  end

endmodule
